// File: rtl/rtc_pkg.sv
// Shared constants for the RTC bus reader: register map, field masks and FSM states.
// The 12/24-hour choice (RTC_HOUR12_EN) is resolved in rtc_bus_reader.
package rtc_pkg;

    localparam int unsigned NUM_REGS = 9;

    typedef logic [3:0] idx_t;

    localparam idx_t IDX_HOUR = 4'd2;
    localparam idx_t IDX_LAST = 4'd8;

    localparam logic [7:0] ADDR_SEC       = 8'h21;
    localparam logic [7:0] ADDR_MIN       = 8'h22;
    localparam logic [7:0] ADDR_HOUR      = 8'h23;
    localparam logic [7:0] ADDR_DAY       = 8'h24;
    localparam logic [7:0] ADDR_MONTH     = 8'h25;
    localparam logic [7:0] ADDR_YEAR      = 8'h26;
    localparam logic [7:0] ADDR_TMR_SEC   = 8'h41;
    localparam logic [7:0] ADDR_TMR_MIN   = 8'h42;
    localparam logic [7:0] ADDR_TMR_HOUR  = 8'h43;

    localparam logic [7:0] MASK_SEC_MIN   = 8'h7F;
    localparam logic [7:0] MASK_DAY       = 8'h3F;
    localparam logic [7:0] MASK_MONTH     = 8'h1F;
    localparam logic [7:0] MASK_NONE      = 8'hFF;
    localparam logic [7:0] MASK_HOUR12    = 8'h1F;
    localparam logic [7:0] MASK_HOUR24    = 8'h3F;
    localparam int unsigned PM_BIT        = 5;

    typedef enum logic [2:0] {
        StIdle,
        StAddrWr,
        StAddrHold,
        StDataRd,
        StDataHold,
        StGap,
        StCommit
    } state_e;

    // Fetch order of the frame: time, date, then countdown timer.
    function automatic logic [7:0] reg_addr(idx_t idx);
        case (idx)
            4'd0:    return ADDR_SEC;
            4'd1:    return ADDR_MIN;
            4'd2:    return ADDR_HOUR;
            4'd3:    return ADDR_DAY;
            4'd4:    return ADDR_MONTH;
            4'd5:    return ADDR_YEAR;
            4'd6:    return ADDR_TMR_SEC;
            4'd7:    return ADDR_TMR_MIN;
            4'd8:    return ADDR_TMR_HOUR;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] reg_mask(idx_t idx);
        case (idx)
            4'd0, 4'd1: return MASK_SEC_MIN;
            4'd3:       return MASK_DAY;
            4'd4:       return MASK_MONTH;
            default:    return MASK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Per-state phase counter: reloads to T_PHASE-1 on state entry, flags the last cycle at 0.
module rtc_phase_timer #(
    parameter int unsigned T_PHASE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic phase_end
);

    logic [7:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else if (load) begin
            count_q <= 8'(T_PHASE - 1);
        end else if (count_q != 8'd0) begin
            count_q <= count_q - 8'd1;
        end
    end

    assign phase_end = (count_q == 8'd0);

endmodule

// File: rtl/rtc_bus_reader.sv
// Reads time, date and timer registers from the RTC multiplexed bus and commits them atomically.
// Define RTC_HOUR12_EN for 12-hour mode (PM flag from hour bit 5).
module rtc_bus_reader
    import rtc_pkg::*;
#(
    parameter int unsigned T_PHASE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic        cs_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        ad_sel,
    output logic [23:0] time_bcd,
    output logic [23:0] date_bcd,
    output logic [23:0] crono_bcd,
    output logic        pm,
    output logic        busy,
    output logic        done
);

`ifdef RTC_HOUR12_EN
    localparam logic [7:0] HOUR_MASK = MASK_HOUR12;
    logic pm_sample;
    assign pm_sample = ad_in[PM_BIT];
`else
    localparam logic [7:0] HOUR_MASK = MASK_HOUR24;
    logic pm_sample;
    assign pm_sample = 1'b0;
`endif

    state_e state_q, state_d;
    idx_t   idx_q, idx_d;
    logic   phase_end;
    logic   addr_phase_d;
    logic [7:0] sample_mask;

    logic [NUM_REGS-1:0][7:0] shadow_q;
    logic                     pm_shadow_q;

    rtc_phase_timer #(
        .T_PHASE (T_PHASE)
    ) u_phase_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (state_d != state_q),
        .phase_end (phase_end)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAddrWr;
                    idx_d   = '0;
                end
            end
            StAddrWr:   if (phase_end) state_d = StAddrHold;
            StAddrHold: if (phase_end) state_d = StDataRd;
            StDataRd:   if (phase_end) state_d = StDataHold;
            StDataHold: if (phase_end) state_d = StGap;
            StGap: begin
                if (phase_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = StCommit;
                    end else begin
                        state_d = StAddrWr;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign addr_phase_d = (state_d == StAddrWr) || (state_d == StAddrHold);

    // Strobes are decoded from the next state so they leave a flop aligned with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_n   <= 1'b1;
            rd_n   <= 1'b1;
            wr_n   <= 1'b1;
            ad_oe  <= 1'b0;
            ad_sel <= 1'b0;
            ad_out <= 8'h00;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            cs_n   <= (state_d == StIdle) || (state_d == StGap) || (state_d == StCommit);
            rd_n   <= (state_d != StDataRd);
            wr_n   <= (state_d != StAddrWr);
            ad_oe  <= addr_phase_d;
            ad_sel <= (state_d == StDataRd) || (state_d == StDataHold);
            ad_out <= addr_phase_d ? reg_addr(idx_d) : 8'h00;
            busy   <= (state_d != StIdle);
            done   <= (state_d == StCommit);
        end
    end

    assign sample_mask = (idx_q == IDX_HOUR) ? HOUR_MASK : reg_mask(idx_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q    <= '0;
            pm_shadow_q <= 1'b0;
        end else if ((state_q == StDataRd) && phase_end) begin
            shadow_q[idx_q] <= ad_in & sample_mask;
            if (idx_q == IDX_HOUR) begin
                pm_shadow_q <= pm_sample;
            end
        end
    end

    // Loaded on the edge into the commit cycle so the fields are valid while done is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_bcd  <= '0;
            date_bcd  <= '0;
            crono_bcd <= '0;
            pm        <= 1'b0;
        end else if (state_d == StCommit) begin
            time_bcd  <= {shadow_q[2], shadow_q[1], shadow_q[0]};
            date_bcd  <= {shadow_q[3], shadow_q[4], shadow_q[5]};
            crono_bcd <= {shadow_q[8], shadow_q[7], shadow_q[6]};
            pm        <= pm_shadow_q;
        end
    end

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Randomized self-checking bench for rtc_bus_reader against a register-map model of the RTC.
// Honours RTC_HOUR12_EN the same way the design does.
module tb_rtc_bus_reader;

    localparam int unsigned TP = 2;
    localparam int MAX_CYC = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  ad_in;
    logic [7:0]  ad_out;
    logic        ad_oe, cs_n, rd_n, wr_n, ad_sel;
    logic [23:0] time_bcd, date_bcd, crono_bcd;
    logic        pm, busy, done;

    rtc_bus_reader #(
        .T_PHASE (TP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ad_in     (ad_in),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .ad_sel    (ad_sel),
        .time_bcd  (time_bcd),
        .date_bcd  (date_bcd),
        .crono_bcd (crono_bcd),
        .pm        (pm),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RTC register file: address latched during the address phase, data driven while rd_n is low.
    logic [7:0] mem [256];
    logic [7:0] rtc_addr = 8'h00;
    logic [7:0] exp_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    assign ad_in = (!cs_n && !rd_n) ? mem[rtc_addr] : 8'hEE;

    always @(negedge clk) if (!cs_n && ad_oe) rtc_addr = ad_out;

    // Committed values the overlay should currently see.
    logic [23:0] exp_time = '0, exp_date = '0, exp_crono = '0;
    logic        exp_pm = 1'b0;

    logic [7:0] addr_log [$];
    int cs_low = 0, rd_low = 0, wr_low = 0, done_count = 0;
    logic prev_rd_n = 1'b1, prev_wr_n = 1'b1, prev_ad_sel = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (ad_sel != prev_ad_sel) check("adsel_strobes", {prev_rd_n, prev_wr_n}, 2'b11);
            if (!wr_n && prev_wr_n) begin
                addr_log.push_back(ad_out);
                check("wr_oe", ad_oe, 1'b1);
            end
            if (!rd_n && prev_rd_n) check("rd_oe", ad_oe, 1'b0);
            if (!cs_n) cs_low++;
            if (!rd_n) rd_low++;
            if (!wr_n) wr_low++;
            if (done) done_count++;
            else begin
                check("hold_time", time_bcd, exp_time);
                check("hold_date", date_bcd, exp_date);
                check("hold_crono", crono_bcd, exp_crono);
                check("hold_pm", pm, exp_pm);
            end
        end
        prev_rd_n   = rd_n;
        prev_wr_n   = wr_n;
        prev_ad_sel = ad_sel;
    end

    function automatic logic [7:0] hour_digits(input logic [7:0] b);
`ifdef RTC_HOUR12_EN
        return b & 8'h1F;
`else
        return b & 8'h3F;
`endif
    endfunction

    function automatic logic hour_pm(input logic [7:0] b);
`ifdef RTC_HOUR12_EN
        return b[5];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model(output logic [23:0] t, output logic [23:0] d, output logic [23:0] c,
                         output logic p);
        t = {hour_digits(mem[8'h23]), mem[8'h22] & 8'h7F, mem[8'h21] & 8'h7F};
        d = {mem[8'h24] & 8'h3F, mem[8'h25] & 8'h1F, mem[8'h26]};
        c = {mem[8'h43], mem[8'h42], mem[8'h41]};
        p = hour_pm(mem[8'h23]);
    endtask

    task automatic set_regs(input logic [71:0] v);
        for (int i = 0; i < 9; i++) mem[exp_addr[i]] = v[71 - 8*i -: 8];
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cs_n"}, cs_n, 1'b1);
        check({tag, "_rd_n"}, rd_n, 1'b1);
        check({tag, "_wr_n"}, wr_n, 1'b1);
        check({tag, "_ad_oe"}, ad_oe, 1'b0);
        check({tag, "_ad_sel"}, ad_sel, 1'b0);
        check({tag, "_ad_out"}, ad_out, 8'h00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_pm"}, pm, 1'b0);
        check({tag, "_time"}, time_bcd, 24'h0);
        check({tag, "_date"}, date_bcd, 24'h0);
        check({tag, "_crono"}, crono_bcd, 24'h0);
    endtask

    // Runs one frame; restart_at > 0 pulses an extra start that many cycles into the frame.
    task automatic do_frame(input string tag, input int restart_at);
        int first, done_at, k, d0;
        logic [23:0] et, ed, ec;
        logic ep;
        model(et, ed, ec, ep);
        addr_log.delete();
        cs_low = 0; rd_low = 0; wr_low = 0;
        d0 = done_count;
        first = -1; done_at = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 1;
        while (done_at < 0 && k < MAX_CYC) begin
            if (first < 0 && !cs_n) first = k;
            if (done) begin
                done_at = k;
                check({tag, "_busy_at_done"}, busy, 1'b1);
                check({tag, "_time"}, time_bcd, et);
                check({tag, "_date"}, date_bcd, ed);
                check({tag, "_crono"}, crono_bcd, ec);
                check({tag, "_pm"}, pm, ep);
                exp_time = et; exp_date = ed; exp_crono = ec; exp_pm = ep;
            end else begin
                start = (k == restart_at);
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        if (done_at < 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_first_addr_wr"}, first, 1);
            check({tag, "_frame_len"}, done_at - first + 1, 45 * TP + 1);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_busy_after"}, busy, 1'b0);
        repeat (20) @(negedge clk);
        check({tag, "_addr_count"}, addr_log.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < addr_log.size()) check({tag, "_addr_order"}, addr_log[i], exp_addr[i]);
        check({tag, "_done_count"}, done_count - d0, 1);
        check({tag, "_cs_low"}, cs_low, 36 * TP);
        check({tag, "_rd_low"}, rd_low, 9 * TP);
        check({tag, "_wr_low"}, wr_low, 9 * TP);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        randomize_mem();
        repeat (3) @(negedge clk);
        check_reset_vals("rst_held");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst_released");

        set_regs(72'h45_30_13_29_03_16_05_10_01);
        do_frame("fixed", 0);
        check("fixed_time_lit", time_bcd, 24'h133045);
        check("fixed_date_lit", date_bcd, 24'h290316);
        check("fixed_crono_lit", crono_bcd, 24'h011005);

        set_regs(72'h59_59_A7_31_12_99_00_00_00);
        do_frame("hour_a7", 0);
`ifdef RTC_HOUR12_EN
        check("hour_a7_digits", time_bcd[23:16], 8'h07);
        check("hour_a7_pm", pm, 1'b1);
`else
        check("hour_a7_digits", time_bcd[23:16], 8'h27);
        check("hour_a7_pm", pm, 1'b0);
`endif

        for (int n = 0; n < 4; n++) begin
            randomize_mem();
            do_frame("random", 0);
        end

        randomize_mem();
        do_frame("restart", 10);

        // Reset while reading the month register (frame index 4).
        randomize_mem();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < MAX_CYC && !found; c++) begin
            @(negedge clk);
            if (!rd_n && rtc_addr == 8'h25) found = 1'b1;
        end
        check("midrst_reached_rd4", found, 1'b1);
        #2;
        exp_time = '0; exp_date = '0; exp_crono = '0; exp_pm = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        randomize_mem();
        do_frame("after_rst", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
